// File: rtl/led_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_share_arbiter
// Brief    : Round-robin sharing of one LED bank among NUM_REQ status
//            sources. A granted pattern is latched and shown for DWELL_CYCLES,
//            followed by a blank gap of GAP_CYCLES before the next grant.
//            Optional macro LED_BLINK_EN blinks the shown pattern with a
//            half-period of BLINK_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module led_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LED_W        = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int GAP_CYCLES   = 5_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LED_W-1:0] pattern,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [LED_W-1:0]         led,
    output logic                     busy
);

    localparam int C_MAX_DG = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int C_MAX    = (C_MAX_DG > BLINK_CYCLES) ? C_MAX_DG : BLINK_CYCLES;
    localparam int CW       = $clog2(C_MAX + 1);
    localparam int PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [CW-1:0] C_DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP_LAST   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [PW-1:0] C_PTR_INIT   = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Owner of the current/last grant doubles as the round-robin pointer.
    state_t              r_state, w_state;
    logic [CW-1:0]       r_cnt,   w_cnt;
    logic [PW-1:0]       r_ptr,   w_ptr;
    logic [NUM_REQ-1:0]  r_grant, w_grant;
    logic [NUM_REQ-1:0]  r_done,  w_done;
    logic [LED_W-1:0]    r_led,   w_led;
    logic                r_busy,  w_busy;

`ifdef LED_BLINK_EN
    localparam logic [CW-1:0] C_BLINK_LAST = (BLINK_CYCLES > 0) ? CW'(BLINK_CYCLES - 1) : '0;
    logic [LED_W-1:0]    r_pat,   w_pat;
    logic [CW-1:0]       r_bcnt,  w_bcnt;
    logic                r_bon,   w_bon;
`endif

    logic                w_found;
    logic [PW-1:0]       w_sel;
    logic [PW-1:0]       w_idx;

    // Round-robin search: first set request after the last owner, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = PW'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_ptr   = r_ptr;
        w_grant = r_grant;
        w_done  = '0;
        w_led   = r_led;
`ifdef LED_BLINK_EN
        w_pat   = r_pat;
        w_bcnt  = r_bcnt;
        w_bon   = r_bon;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state        = S_SHOW;
                    w_cnt          = '0;
                    w_ptr          = w_sel;
                    w_grant        = '0;
                    w_grant[w_sel] = 1'b1;
                    w_led          = pattern[w_sel*LED_W +: LED_W];
`ifdef LED_BLINK_EN
                    w_pat          = pattern[w_sel*LED_W +: LED_W];
                    w_bcnt         = '0;
                    w_bon          = 1'b1;
`endif
                end
            end
            S_SHOW: begin
                // Normal end has priority over a coincident request drop.
                if ((r_cnt == C_DWELL_LAST) || !req[r_ptr]) begin
                    if (r_cnt == C_DWELL_LAST) begin
                        w_done[r_ptr] = 1'b1;
                    end
                    w_grant = '0;
                    w_led   = '0;
                    w_cnt   = '0;
                    w_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
`ifdef LED_BLINK_EN
                    if (r_bcnt == C_BLINK_LAST) begin
                        w_bcnt = '0;
                        w_bon  = ~r_bon;
                        w_led  = r_bon ? '0 : r_pat;
                    end else begin
                        w_bcnt = r_bcnt + 1'b1;
                        w_led  = r_bon ? r_pat : '0;
                    end
`endif
                end
            end
            S_GAP: begin
                if (r_cnt == C_GAP_LAST) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
                w_grant = '0;
                w_led   = '0;
            end
        endcase
        w_busy = (w_state != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= C_PTR_INIT;
            r_grant <= '0;
            r_done  <= '0;
            r_led   <= '0;
            r_busy  <= 1'b0;
`ifdef LED_BLINK_EN
            r_pat   <= '0;
            r_bcnt  <= '0;
            r_bon   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_ptr   <= w_ptr;
            r_grant <= w_grant;
            r_done  <= w_done;
            r_led   <= w_led;
            r_busy  <= w_busy;
`ifdef LED_BLINK_EN
            r_pat   <= w_pat;
            r_bcnt  <= w_bcnt;
            r_bon   <= w_bon;
`endif
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign led   = r_led;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_share_arbiter
// Brief    : Self-checking bench for led_share_arbiter: directed scenarios
//            followed by randomized requests/patterns, all compared against a
//            behavioural model that tracks owner, age and gap time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_share_arbiter;

    localparam int N  = 4;
    localparam int LW = 4;
    localparam int DW = 10;
    localparam int GP = 3;
    localparam int BL = 2;
`ifdef LED_BLINK_EN
    localparam int BLINK_ON = 1;
`else
    localparam int BLINK_ON = 0;
`endif

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*LW-1:0] pattern = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [LW-1:0]   led;
    logic            busy;

    always #5 clk = ~clk;

    led_share_arbiter #(
        .NUM_REQ      (N),
        .LED_W        (LW),
        .DWELL_CYCLES (DW),
        .GAP_CYCLES   (GP),
        .BLINK_CYCLES (BL)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .req     (req),
        .pattern (pattern),
        .grant   (grant),
        .done    (done),
        .led     (led),
        .busy    (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: mode 0 idle, 1 showing, 2 blank gap.
    int            m_mode;
    int            m_owner;
    int            m_last;
    int            m_age;
    int            m_gap_age;
    logic [LW-1:0] m_pat;
    logic [LW-1:0] m_led;
    logic [N-1:0]  m_grant;
    logic [N-1:0]  m_done;
    logic          m_busy;

    int            dut_dones;
    int            gq[$];
    logic [N-1:0]  prev_grant;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] show_led(input logic [LW-1:0] p, input int age);
        if (BLINK_ON != 0 && ((age / BL) % 2) == 1) return '0;
        return p;
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        m_owner    = 0;
        m_last     = N - 1;
        m_age      = 0;
        m_gap_age  = 0;
        m_pat      = '0;
        m_led      = '0;
        m_grant    = '0;
        m_done     = '0;
        m_busy     = 1'b0;
        prev_grant = '0;
    endtask

    task automatic model_release();
        m_grant   = '0;
        m_led     = '0;
        m_gap_age = 0;
        m_mode    = (GP > 0) ? 2 : 0;
    endtask

    task automatic model_step();
        bit found;
        m_done = '0;
        case (m_mode)
            0: begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (!found && req[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                    end
                end
                if (found) begin
                    m_last  = m_owner;
                    m_pat   = pattern[m_owner*LW +: LW];
                    m_age   = 0;
                    m_mode  = 1;
                    m_grant = N'(1) << m_owner;
                    m_led   = show_led(m_pat, 0);
                end
            end
            1: begin
                if (m_age == DW - 1) begin
                    m_done[m_owner] = 1'b1;
                    model_release();
                end else if (!req[m_owner]) begin
                    model_release();
                end else begin
                    m_age++;
                    m_led = show_led(m_pat, m_age);
                end
            end
            default: begin
                if (m_gap_age == GP - 1) m_mode = 0;
                else m_gap_age++;
            end
        endcase
        m_busy = (m_mode != 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (nrst) model_step();
        @(negedge clk);
        chk("grant", grant, m_grant);
        chk("led",   led,   m_led);
        chk("done",  done,  m_done);
        chk("busy",  busy,  m_busy);
        if (done != '0) dut_dones++;
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) gq.push_back(i);
        end
        prev_grant = grant;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        nrst    = 1'b0;
        req     = '0;
        pattern = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_led",   led,   0);
        chk("rst_done",  done,  0);
        chk("rst_busy",  busy,  0);
        nrst = 1'b1;
    endtask

    task automatic settle();
        req = '0;
        repeat (20) cycle();
    endtask

    initial begin
        bit hit;
        model_reset();

        // Lone requester: grant 1 cycle after req, 10-cycle dwell, re-grant.
        apply_reset();
        dut_dones = 0;
        gq.delete();
        req = 4'b0001;
        pattern[0 +: LW] = 4'hA;
        repeat (30) cycle();
        chk("s1_dones", dut_dones, 2);
        chk("s1_grants", gq.size(), 3);

        // Continuous 1011: order 0,1,3,0 from reset.
        apply_reset();
        gq.delete();
        req = 4'b1011;
        pattern = 16'h9C76;
        repeat (60) cycle();
        chk("s2_n", (gq.size() >= 4) ? 1 : 0, 1);
        if (gq.size() >= 4) begin
            chk("s2_g0", gq[0], 0);
            chk("s2_g1", gq[1], 1);
            chk("s2_g2", gq[2], 3);
            chk("s2_g3", gq[3], 0);
        end

        // Abort: drop req[1] partway through its dwell.
        settle();
        dut_dones = 0;
        req = 4'b0010;
        pattern[LW +: LW] = 4'h5;
        hit = 1'b0;
        for (int w = 0; w < 40 && !hit; w++) begin
            cycle();
            if (m_mode == 1 && m_owner == 1 && m_age == 4) hit = 1'b1;
        end
        chk("s3_reached", hit, 1);
        req = '0;
        cycle();
        chk("s3_grant_off", grant, 0);
        chk("s3_led_off",   led,   0);
        repeat (6) cycle();
        chk("s3_no_done", dut_dones, 0);

        // Pattern change during SHOW is ignored.
        settle();
        req = 4'b0010;
        pattern[LW +: LW] = 4'h5;
        repeat (5) cycle();
        pattern[LW +: LW] = 4'hF;
        repeat (3) cycle();
        chk("s4_led_hold", led, show_led(4'h5, 7));
        repeat (10) cycle();

        // Asynchronous reset mid-SHOW, then search restarts at source 0.
        settle();
        req = 4'b0001;
        pattern[0 +: LW] = 4'h3;
        repeat (4) cycle();
        #2 nrst = 1'b0;
        #1;
        chk("s5_grant", grant, 0);
        chk("s5_led",   led,   0);
        chk("s5_done",  done,  0);
        chk("s5_busy",  busy,  0);
        model_reset();
        req = 4'b1000;
        pattern[3*LW +: LW] = 4'h6;
        @(negedge clk);
        nrst = 1'b1;
        cycle();
        chk("s5_regrant", grant, 4'b1000);
        repeat (20) cycle();

        // Randomized requests and patterns.
        apply_reset();
        for (int r = 0; r < 800; r++) begin
            if ($urandom_range(7) == 0) begin
                int b;
                b = $urandom_range(N - 1);
                req[b] = ~req[b];
            end
            if ($urandom_range(3) == 0) pattern = N*LW'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_share_arbiter.md
Name: led_share_arbiter

Overview:
- Shares the board's 4 LEDs among NUM_REQ status sources.
- Each source raises a request with a 4-bit pattern. The block grants sources in round-robin order and shows the granted pattern for a fixed dwell time.
- Between grants it blanks the LEDs for a short gap, then serves the next requester.
- Sits between the status-producing logic and the LED output pins. It replaces free-running LED timers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LED_W, 4, LED vector width.
- DWELL_CYCLES, 50_000_000, cycles a granted pattern is shown (1 s at 50 MHz); must be >= 1.
- GAP_CYCLES, 5_000_000, blank cycles after each grant ends (100 ms); 0 means no gap.
- BLINK_CYCLES, 12_500_000, blink half-period; used only with LED_BLINK_EN.

Ports:
- clk  in  1  system clock, 50 MHz.
- nrst  in  1  asynchronous reset, active-low.
- req  in  NUM_REQ  per-source request, level-sensitive.
- pattern  in  NUM_REQ*LED_W  per-source pattern; source i occupies bits [i*LED_W +: LED_W].
- grant  out  NUM_REQ  one-hot current owner; all zero when none.
- done  out  NUM_REQ  one-cycle pulse when the owner's dwell completes normally.
- led  out  LED_W  LED drive, active-high.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset is asynchronous and active-low on nrst, clocked on clk. During reset:
  - led = 0, grant = 0, done = 0, busy = 0.
  - state = IDLE, counter = 0.
  - last-grant pointer ptr = NUM_REQ-1, so req[0] wins first.
- States: IDLE, SHOW, GAP. All outputs are registered.
- IDLE:
  - If any req bit is set, select the first set bit searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - On the next edge:
    - grant <= onehot(sel);
    - led <= pattern[sel], latched;
    - ptr <= sel;
    - counter <= 0;
    - state <= SHOW.
  - Latency from req seen high in IDLE to grant/led is 1 cycle.
- SHOW:
  - led holds the latched pattern. Changes on pattern[sel] are ignored until the next grant.
  - counter increments each cycle.
  - Normal end: when counter == DWELL_CYCLES-1, on the next edge:
    - done[sel] <= 1 for one cycle;
    - grant <= 0, led <= 0, counter <= 0;
    - state <= GAP, or IDLE if GAP_CYCLES == 0.
  - Total grant duration is exactly DWELL_CYCLES cycles.
- Abort: if req[sel] is low in any SHOW cycle before the last, on the next edge:
  - grant <= 0, led <= 0, no done pulse;
  - go to GAP (or IDLE if GAP_CYCLES == 0).
  - If the abort and the final dwell cycle coincide, normal end wins and done pulses.
- GAP:
  - led = 0, grant = 0.
  - counter counts 0..GAP_CYCLES-1, then goes to IDLE with counter <= 0.
  - Requests arriving during GAP wait.
- Fairness:
  - A source that keeps req high after done is re-eligible, but the search starts after it. All other pending sources are served first.
  - A single lone requester is re-granted after each gap.
- Counter width = $clog2(max(DWELL_CYCLES, GAP_CYCLES, BLINK_CYCLES)+1). No wrap occurs inside a state.
- Only grant, led and done change on grant transitions. done is never high while grant is nonzero for the same index.

Optional Feature:
- Macro LED_BLINK_EN.
- Defined: during SHOW, led alternates between the latched pattern and 0 every BLINK_CYCLES cycles.
  - It starts with the pattern on in the first SHOW cycle.
  - The blink phase counter resets at every grant.
  - Dwell, abort and done timing are unchanged.
- Undefined: led is steady at the pattern for the whole SHOW state, and BLINK_CYCLES is unused.

Test Plan:
(sim params: NUM_REQ=4, DWELL_CYCLES=10, GAP_CYCLES=3, BLINK_CYCLES=2)
1. Reset then req=4'b0001, pattern0=4'hA held -> 1 cycle later grant=0001, led=A for exactly 10 cycles; done[0] pulses once; led=0 for 3 cycles; then re-grant.
2. req=4'b1011 held continuously -> grants in order 0,1,3,0, each 10 cycles, separated by 3-cycle gaps with led=0.
3. Grant to source 1, drop req[1] at SHOW cycle 4 -> next edge grant=0, led=0, no done[1]; 3-cycle gap; then IDLE.
4. Change pattern1 from 4'h5 to 4'hF mid-SHOW -> led stays 5 until the dwell ends.
5. Assert nrst=0 mid-SHOW -> led, grant, done immediately 0; after release with req=4'b1000, grant=1000 (search starts at 0, first set bit is 3).
6. With LED_BLINK_EN and pattern 4'h3 -> led sequence in SHOW is 3,3,0,0,3,3,0,0,3,3; done at the end as in scenario 1.
